tmds_chan_decode: RTL and testbench

TMDS_CHAN_DECODE -- requirements
Module: tmds_chan_decode

---
 rtl/tmds_pkg.sv | 16 +
 rtl/tmds_char_decode.sv | 40 ++++
 rtl/tmds_chan_decode.sv | 147 ++++++++++++++
 tb/tb_tmds_chan_decode.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Definitions shared by the TMDS encoder and decoder: the four control tokens
// and the channel alignment state encoding.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        LOCKED = 2'd2
    } tmds_state_e;

endpackage

// File: rtl/tmds_char_decode.sv
// Combinational decode of one 10-bit TMDS character into a pixel byte or a
// control pair. Shared by all three colour channels.
module tmds_char_decode
    import tmds_pkg::*;
(
    input  logic [9:0] din,
    output logic [7:0] dout,
    output logic       c0,
    output logic       c1,
    output logic       is_ctrl
);

    logic [7:0] q;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        dout    = '0;
        c0      = 1'b0;
        c1      = 1'b0;
        is_ctrl = 1'b1;
        q       = din[9] ? ~din[7:0] : din[7:0];
        case (din)
            CTRL_TOK_00: ;
            CTRL_TOK_01: c0 = 1'b1;
            CTRL_TOK_10: c1 = 1'b1;
            CTRL_TOK_11: begin
                c0 = 1'b1;
                c1 = 1'b1;
            end
            default: begin
                is_ctrl = 1'b0;
                dout[0] = q[0];
                for (int i = 1; i < 8; i++) begin
                    dout[i] = din[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
                end
            end
        endcase
    end

endmodule

// File: rtl/tmds_chan_decode.sv
// One TMDS channel: 2-stage character decode plus the word-alignment state
// machine that drives the deserializer bitslip.
module tmds_chan_decode
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN     = 64,
    parameter int SRCH_TIMEOUT = 4096,
    parameter int SLIP_HOLD    = 16,
    parameter int LOSS_TIMEOUT = 4096
) (
    input  logic        pix_clk,
    input  logic        sys_rst,
    input  logic [9:0]  din,
    output logic [7:0]  dout,
    output logic        c0,
    output logic        c1,
    output logic        vde,
    output logic        aligned,
    output logic        bitslip,
    output logic [15:0] err_cnt
);

    localparam int RUN_W  = $clog2(CTRL_RUN) + 1;
    localparam int TMO_W  = $clog2(SRCH_TIMEOUT) + 1;
    localparam int HOLD_W = $clog2(SLIP_HOLD) + 1;
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT) + 1;

    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(CTRL_RUN);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(SRCH_TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(SLIP_HOLD - 1);
    localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(LOSS_TIMEOUT);

    logic [9:0]        din_q;
    logic [7:0]        dec_dout;
    logic              dec_c0;
    logic              dec_c1;
    logic              dec_ctrl;

    tmds_state_e       state;
    tmds_state_e       state_next;
    logic              slip_req;
    logic              lock_lost;
    logic [RUN_W-1:0]  run_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [LOSS_W-1:0] loss_cnt;
    logic [LOSS_W-1:0] loss_next;

    tmds_char_decode u_char_decode (
        .din     (din_q),
        .dout    (dec_dout),
        .c0      (dec_c0),
        .c1      (dec_c1),
        .is_ctrl (dec_ctrl)
    );

    always_comb begin
        state_next = state;
        slip_req   = 1'b0;
        lock_lost  = 1'b0;
        if (dec_ctrl)
            loss_next = '0;
        else if (loss_cnt != LOSS_MAX)
            loss_next = loss_cnt + LOSS_W'(1);
        else
            loss_next = loss_cnt;

        case (state)
            SEARCH: begin
                // A full control run takes priority over a timeout in the same cycle.
                if (run_cnt == RUN_MAX) begin
                    state_next = LOCKED;
                end else if (tmo_cnt == TMO_MAX) begin
                    state_next = SLIP;
                    slip_req   = 1'b1;
                end
            end
            SLIP: begin
                if (hold_cnt == HOLD_END)
                    state_next = SEARCH;
            end
            LOCKED: begin
                if (loss_next == LOSS_MAX) begin
                    state_next = SEARCH;
                    lock_lost  = 1'b1;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge pix_clk) begin
        // NOTE: pipeline and decode registers are reset too, so no stale character leaks out after reset.
        if (sys_rst) begin
            din_q    <= '0;
            dout     <= '0;
            c0       <= 1'b0;
            c1       <= 1'b0;
            vde      <= 1'b0;
            state    <= SEARCH;
            aligned  <= 1'b0;
            bitslip  <= 1'b0;
            err_cnt  <= '0;
            run_cnt  <= '0;
            tmo_cnt  <= '0;
            hold_cnt <= '0;
            loss_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            din_q <= din;
            if (dec_ctrl) begin
                vde  <= 1'b0;
                dout <= '0;
                c0   <= dec_c0;
                c1   <= dec_c1;
            end else begin
                vde  <= 1'b1;
                dout <= dec_dout;
            end

            state   <= state_next;
            aligned <= (state_next == LOCKED);
            bitslip <= slip_req;

            if (state == SLIP || !dec_ctrl)
                run_cnt <= '0;
            else if (run_cnt != RUN_MAX)
                run_cnt <= run_cnt + RUN_W'(1);

            if (state == SEARCH && state_next == SEARCH && tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            else if (state != SEARCH || state_next != SEARCH)
                tmo_cnt <= '0;

            if (state == SLIP && state_next == SLIP)
                hold_cnt <= hold_cnt + HOLD_W'(1);
            else
                hold_cnt <= '0;

            loss_cnt <= (state == LOCKED) ? loss_next : '0;

            if (lock_lost && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_tmds_chan_decode.sv
// Directed bench for tmds_chan_decode: lock, pixel decode, lock loss, bitslip
// search, a shortened 1080p blue-channel stream and reset during bitslip.
module tb_tmds_chan_decode;
    import tmds_pkg::*;

    logic        pix_clk = 1'b0;
    logic        sys_rst;
    logic [9:0]  din;
    logic [7:0]  dout;
    logic        c0;
    logic        c1;
    logic        vde;
    logic        aligned;
    logic        bitslip;
    logic [15:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int slip_seen = 0;
    int enc_disp = 0;

    tmds_chan_decode dut (
        .pix_clk (pix_clk),
        .sys_rst (sys_rst),
        .din     (din),
        .dout    (dout),
        .c0      (c0),
        .c1      (c1),
        .vde     (vde),
        .aligned (aligned),
        .bitslip (bitslip),
        .err_cnt (err_cnt)
    );

    always #5 pix_clk = ~pix_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge pix_clk);
        #1;
        cyc++;
        if (bitslip) slip_seen++;
    endtask

    function automatic logic [9:0] tok(input logic v, input logic h);
        case ({v, h})
            2'b00:   return CTRL_TOK_00;
            2'b01:   return CTRL_TOK_01;
            2'b10:   return CTRL_TOK_10;
            default: return CTRL_TOK_11;
        endcase
    endfunction

    function automatic logic [9:0] rotr(input logic [9:0] w, input int n);
        logic [19:0] dd;
        dd = {w, w} >> n;
        return dd[9:0];
    endfunction

    // Reference DVI 8b/10b encoder with running disparity held in enc_disp.
    task automatic encode(input logic [7:0] d, output logic [9:0] w);
        logic [8:0] qm;
        int n1, n1q, n0q;
        n1 = $countones(d);
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_disp == 0 || n1q == n0q) begin
            w = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            enc_disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((enc_disp > 0 && n1q > n0q) || (enc_disp < 0 && n0q > n1q)) begin
            w = {1'b1, qm[8], ~qm[7:0]};
            enc_disp += 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            w = {1'b0, qm[8], qm[7:0]};
            enc_disp += -2 * int'(!qm[8]) + n1q - n0q;
        end
    endtask

    task automatic do_reset(input logic [9:0] w);
        din     = w;
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst   = 1'b0;
        slip_seen = 0;
    endtask

    initial begin
        logic [7:0] pix [4];
        logic [9:0] w;
        int slip_t [8];
        int n_slip, off, rise_t, rises, drops;
        logic c0_prev, locked_once, found;

        pix[0] = 8'h00; pix[1] = 8'h55; pix[2] = 8'hA5; pix[3] = 8'hFF;

        // Reset values
        din = 10'h3FF;
        sys_rst = 1'b1;
        tick();
        check("rst_dout", dout, 8'h00);
        check("rst_flags", {c1, c0, vde, aligned, bitslip}, 5'b0);
        check("rst_err", err_cnt, 16'h0);
        check("rst_state", dut.state, SEARCH);
        do_reset(CTRL_TOK_00);

        // Lock on a run of 00 control tokens
        for (int k = 1; k <= 100; k++) begin
            din = CTRL_TOK_00;
            tick();
            if (k == 65) check("lock_early", aligned, 1'b0);
            if (k == 66) check("lock_rise", aligned, 1'b1);
        end
        check("lock_ctl", {vde, c1, c0}, 3'b000);
        check("lock_noslip", slip_seen, 0);

        // Encoded pixels come out two cycles later
        enc_disp = 0;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) encode(pix[i], w);
            else w = CTRL_TOK_00;
            din = w;
            tick();
            if (i >= 1) begin
                check("pix_dout", dout, pix[i-1]);
                check("pix_vde", {vde, c1, c0}, 3'b100);
            end
        end

        // Lock loss after a long run of data words
        for (int k = 0; k < 4; k++) begin
            din = CTRL_TOK_00;
            tick();
        end
        check("loss_pre", {aligned, err_cnt}, {1'b1, 16'd0});
        for (int k = 1; k <= 4097; k++) begin
            din = 10'h100;
            tick();
            if (k == 4096) check("loss_hold", aligned, 1'b1);
        end
        check("loss_fall", aligned, 1'b0);
        check("loss_err", err_cnt, 16'd1);
        check("loss_state", dut.state, SEARCH);

        // Blue channel, 2200-cycle lines with a shortened 8-line frame
        do_reset(CTRL_TOK_00);
        enc_disp = 0;
        c0_prev = 1'b0; rise_t = -1; rises = 0; drops = 0; locked_once = 1'b0;
        for (int ln = 0; ln < 17; ln++) begin
            for (int x = 0; x < 2200; x++) begin
                if (x < 1920 && (ln % 8) < 6) begin
                    encode(8'((x + ln) & 8'hFF), w);
                end else begin
                    w = tok((ln % 8) == 6, x >= 2008 && x < 2052);
                    enc_disp = 0;
                end
                din = w;
                tick();
                if (c0 && !c0_prev) begin
                    if (rise_t >= 0) check("hs_period", cyc - rise_t, 2200);
                    rise_t = cyc;
                    rises++;
                end
                if (!c0 && c0_prev) check("hs_width", cyc - rise_t, 44);
                c0_prev = c0;
                if (aligned) locked_once = 1'b1;
                else if (locked_once) drops++;
            end
        end
        check("hs_locked", locked_once, 1'b1);
        check("hs_drops", drops, 0);
        check("hs_rises", rises, 17);
        check("hs_noslip", slip_seen, 0);

        // Bitslip search on a word rotated by 3 bits
        off = 3;
        n_slip = 0;
        do_reset(rotr(CTRL_TOK_00, off));
        for (int k = 0; k < 20000 && !aligned; k++) begin
            din = rotr(CTRL_TOK_00, off);
            tick();
            if (bitslip) begin
                if (n_slip < 8) slip_t[n_slip] = cyc;
                n_slip++;
                off = (off + 9) % 10;
            end
        end
        for (int k = 0; k < 200; k++) begin
            din = rotr(CTRL_TOK_00, off);
            tick();
        end
        check("slip_count", slip_seen, 3);
        check("slip_gap1", slip_t[1] - slip_t[0], 4096 + 16 + 1);
        check("slip_gap2", slip_t[2] - slip_t[1], 4096 + 16 + 1);
        check("slip_aligned", aligned, 1'b1);

        // Reset asserted in the bitslip cycle
        do_reset(rotr(CTRL_TOK_00, 3));
        found = 1'b0;
        for (int k = 0; k < 5000 && !found; k++) begin
            tick();
            found = bitslip;
        end
        check("rs_found", found, 1'b1);
        sys_rst = 1'b1;
        tick();
        check("rs_bitslip", bitslip, 1'b0);
        check("rs_outs", {dout, c1, c0, vde, aligned, err_cnt}, 28'h0);
        check("rs_state", dut.state, SEARCH);
        sys_rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
